// File: rtl/instr_encoder_if.sv
// instr_encoder_if: groups the request handshake and the instruction-memory
// write port of instr_encoder.
//   master : sequencer / memory side (issues requests, accepts writes)
//   slave  : encoder side
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_mode;
    logic [3:0]        req_opcode;
    logic              req_s;
    logic [3:0]        req_cond;
    logic              req_imm;
    logic [3:0]        req_rn;
    logic [3:0]        req_rd;
    logic [23:0]       req_operand;
    logic              req_last;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;

    modport master (
        output req_valid, req_mode, req_opcode, req_s, req_cond, req_imm,
               req_rn, req_rd, req_operand, req_last, mem_wr_ready,
        input  req_ready, mem_wr_valid, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  req_valid, req_mode, req_opcode, req_s, req_cond, req_imm,
               req_rn, req_rd, req_operand, req_last, mem_wr_ready,
        output req_ready, mem_wr_valid, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction requests into 32-bit instruction
// words and streams them into instruction memory at consecutive word
// addresses through a small registered FIFO.
//
// Optional feature: define INSTR_ENCODER_CHECK_EN to reject illegal requests
// (handshaken but not written) and expose the sticky `err` flag.
module instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4      // power of two, >= 2
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic              done,
    output logic [ADDR_W-1:0] word_count
`ifdef INSTR_ENCODER_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] MODE_DP = 2'b00;
    localparam logic [1:0] MODE_LS = 2'b01;
    localparam logic [1:0] MODE_BR = 2'b10;
    localparam logic [1:0] MODE_RV = 2'b11;

    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state;
    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    occupancy;
    logic [ADDR_W-1:0] addr_q;

    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic        legal;
    logic        drain_empty;
    logic        dp_s;
    logic [3:0]  dp_rn;
    logic [3:0]  dp_rd;
    logic [31:0] enc_word;

    assign full  = (occupancy == (PTR_W+1)'(DEPTH));
    assign empty = (occupancy == '0);

    // Compare/test opcodes always set flags and have no destination; moves
    // have no first operand. Those fields are forced regardless of the request.
    // NOTE: every signal assigned in an always_comb gets a default on the first
    // lines so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        dp_s  = bus.req_s;
        dp_rn = bus.req_rn;
        dp_rd = bus.req_rd;
        if (bus.req_opcode == OP_CMP || bus.req_opcode == OP_TST) begin
            dp_s  = 1'b1;
            dp_rd = 4'h0;
        end
        if (bus.req_opcode == OP_MOV || bus.req_opcode == OP_MVN) begin
            dp_rn = 4'h0;
        end
    end

    // Pack the request fields into the decode-stage word layout. The reserved
    // mode falls through to the data-proc layout and keeps its mode bits.
    always_comb begin
        enc_word = '0;
        case (bus.req_mode)
            MODE_LS: enc_word = {bus.req_cond, 2'b01, 1'b0, 4'b0100, bus.req_s,
                                 bus.req_rn, bus.req_rd, bus.req_operand[11:0]};
            MODE_BR: enc_word = {bus.req_cond, 3'b101, 1'b0, bus.req_operand};
            default: enc_word = {bus.req_cond, bus.req_mode, bus.req_imm,
                                 bus.req_opcode, dp_s, dp_rn, dp_rd,
                                 bus.req_operand[11:0]};
        endcase
    end

`ifdef INSTR_ENCODER_CHECK_EN
    logic legal_op;

    // Legality: known mode, implemented data-proc opcode, and no stray bits
    // above the 12-bit operand for data-proc and load/store.
    always_comb begin
        case (bus.req_opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110,
            4'b1000, 4'b1010, 4'b1100, 4'b1101, 4'b1111: legal_op = 1'b1;
            default:                                      legal_op = 1'b0;
        endcase
        legal = 1'b1;
        if (bus.req_mode == MODE_RV) begin
            legal = 1'b0;
        end
        if (bus.req_mode == MODE_DP && !legal_op) begin
            legal = 1'b0;
        end
        if ((bus.req_mode == MODE_DP || bus.req_mode == MODE_LS) &&
            bus.req_operand[23:12] != 12'h000) begin
            legal = 1'b0;
        end
    end
`else
    assign legal = 1'b1;
`endif

    // A full FIFO never accepts, even when the head is leaving this cycle.
    assign bus.req_ready = (state == ST_RUN) && !full;
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = accept && legal;

    assign bus.mem_wr_valid = !empty;
    assign pop              = bus.mem_wr_valid && bus.mem_wr_ready;
    assign bus.mem_wr_addr  = addr_q;
    // Storage is not reset, so an empty FIFO presents zero rather than stale data.
    assign bus.mem_wr_data  = empty ? 32'h0 : fifo_mem[rd_ptr];

    assign done = (state == ST_DONE);

    // The FIFO holds nothing after this cycle: already empty, or its last
    // entry is written now (no pushes are possible while draining).
    assign drain_empty = empty || ((occupancy == (PTR_W+1)'(1)) && pop);

    // FIFO storage: written on push only.
    // NOTE: the data array has no reset; validity is carried entirely by the
    // reset pointers and occupancy, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    // FIFO pointers and occupancy; reset discards every queued word.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + (PTR_W+1)'(1);
                2'b01:   occupancy <= occupancy - (PTR_W+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Load sequencing plus the write address and word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            word_count <= '0;
        end else begin
            if (pop) begin
                addr_q     <= addr_q + ADDR_W'(4);
                word_count <= word_count + ADDR_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        addr_q     <= base_addr;
                        word_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept && bus.req_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef INSTR_ENCODER_CHECK_EN
    // Sticky illegal-request flag, cleared when a new load starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            err <= 1'b0;
        end else if (accept && !legal) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed stimulus for instr_encoder,
// checked every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_instr_encoder;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
`ifdef INSTR_ENCODER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              done;
    logic [ADDR_W-1:0] word_count;
`ifdef INSTR_ENCODER_CHECK_EN
    logic              err;
`endif

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .done       (done),
        .word_count (word_count)
`ifdef INSTR_ENCODER_CHECK_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic logic [31:0] ref_encode(input logic [1:0] mode, input logic [3:0] op,
                                               input logic s, input logic [3:0] cond,
                                               input logic imm, input logic [3:0] rn,
                                               input logic [3:0] rd, input logic [23:0] operand);
        logic [31:0] w;
        logic [31:0] s_v;
        logic [31:0] rn_v;
        logic [31:0] rd_v;
        logic [31:0] low12;
        low12 = 32'(operand) & 32'h0000_0FFF;
        w = 32'(cond) << 28;
        if (mode == 2'b01) begin
            w = w | (32'd1 << 26) | (32'd4 << 21) | (32'(s) << 20) |
                (32'(rn) << 16) | (32'(rd) << 12) | low12;
        end else if (mode == 2'b10) begin
            w = w | (32'd5 << 25) | 32'(operand);
        end else begin
            s_v  = (op == 4'd8 || op == 4'd10) ? 32'd1 : 32'(s);
            rd_v = (op == 4'd8 || op == 4'd10) ? 32'd0 : 32'(rd);
            rn_v = (op == 4'd13 || op == 4'd15) ? 32'd0 : 32'(rn);
            w = w | (32'(mode) << 26) | (32'(imm) << 25) | (32'(op) << 21) |
                (s_v << 20) | (rn_v << 16) | (rd_v << 12) | low12;
        end
        return w;
    endfunction

    function automatic bit ref_legal(input logic [1:0] mode, input logic [3:0] op,
                                     input logic [23:0] operand);
        bit bad;
        bad = (mode == 2'b11) ||
              (mode == 2'b00 && !(op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
                                             4'd8, 4'd10, 4'd12, 4'd13, 4'd15})) ||
              (mode != 2'b10 && (operand >> 12) != 24'd0);
        return CHECK_EN ? !bad : 1'b1;
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;
    phase_t      m_phase = P_IDLE;
    logic [31:0] m_q[$];
    logic [31:0] m_addr  = '0;
    logic [31:0] m_count = '0;
    bit          m_err   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = P_IDLE;
            m_q.delete();
            m_addr  = '0;
            m_count = '0;
            m_err   = 1'b0;
        end else begin : upd
            bit     can_take;
            bit     acc;
            bit     wr;
            phase_t nxt;
            can_take = (m_phase == P_RUN) && (m_q.size() < DEPTH);
            acc      = bus.req_valid && can_take;
            wr       = (m_q.size() > 0) && bus.mem_wr_ready;
            nxt      = m_phase;
            if (wr) begin
                void'(m_q.pop_front());
                m_addr  = m_addr + 32'd4;
                m_count = m_count + 32'd1;
            end
            if (acc) begin
                if (ref_legal(bus.req_mode, bus.req_opcode, bus.req_operand))
                    m_q.push_back(ref_encode(bus.req_mode, bus.req_opcode, bus.req_s,
                                             bus.req_cond, bus.req_imm, bus.req_rn,
                                             bus.req_rd, bus.req_operand));
                else
                    m_err = 1'b1;
                if (bus.req_last) nxt = P_DRAIN;
            end
            case (m_phase)
                P_IDLE: if (start) begin
                    nxt     = P_RUN;
                    m_addr  = base_addr;
                    m_count = '0;
                    m_err   = 1'b0;
                end
                P_DRAIN: if (m_q.size() == 0) nxt = P_DONE;
                P_DONE:  nxt = P_IDLE;
                default: ;
            endcase
            m_phase = nxt;
        end
    end

    // Per-cycle comparison of every output against the model, mid-cycle.
    always @(negedge clk) begin
        check("req_ready", bus.req_ready, (m_phase == P_RUN) && (m_q.size() < DEPTH));
        check("mem_wr_valid", bus.mem_wr_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("mem_wr_data", bus.mem_wr_data, m_q[0]);
        if (!rst) check("mem_wr_data_rst", bus.mem_wr_data, 0);
        check("mem_wr_addr", bus.mem_wr_addr, m_addr);
        check("done", done, m_phase == P_DONE);
        check("word_count", word_count, m_count);
`ifdef INSTR_ENCODER_CHECK_EN
        check("err", err, m_err);
`endif
    end

    // Write log and acceptance counter for directed expectations.
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          acc_count = 0;
    always @(posedge clk) begin
        if (rst && bus.mem_wr_valid && bus.mem_wr_ready) begin
            log_addr.push_back(bus.mem_wr_addr);
            log_data.push_back(bus.mem_wr_data);
        end
        if (rst && bus.req_valid && bus.req_ready) acc_count++;
    end

    // Random write-port back-pressure when enabled.
    bit rand_ready = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) bus.mem_wr_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus tasks (enter/exit at posedge + 1) ----------------
    task automatic do_start(input logic [31:0] base);
        base_addr = base;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic present(input logic [1:0] mode, input logic [3:0] op, input logic s,
                           input logic [3:0] cond, input logic imm, input logic [3:0] rn,
                           input logic [3:0] rd, input logic [23:0] operand, input logic last);
        bus.req_mode    = mode;
        bus.req_opcode  = op;
        bus.req_s       = s;
        bus.req_cond    = cond;
        bus.req_imm     = imm;
        bus.req_rn      = rn;
        bus.req_rd      = rd;
        bus.req_operand = operand;
        bus.req_last    = last;
        bus.req_valid   = 1'b1;
    endtask

    task automatic send(input logic [1:0] mode, input logic [3:0] op, input logic s,
                        input logic [3:0] cond, input logic imm, input logic [3:0] rn,
                        input logic [3:0] rd, input logic [23:0] operand, input logic last);
        bit hs = 1'b0;
        int budget = 0;
        present(mode, op, s, cond, imm, rn, rd, operand, last);
        while (!hs && budget < 300) begin
            @(posedge clk);
            hs = bus.req_ready;
            #1;
            budget++;
        end
        if (!hs) check("send_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_words, input string tag);
        int b = 0;
        while (!done && b < 1000) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (!done) check({tag, "_done_timeout"}, 0, 1);
        else check({tag, "_word_count"}, word_count, 64'(exp_words));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.req_valid    = 1'b0;
        bus.req_mode     = '0;
        bus.req_opcode   = '0;
        bus.req_s        = 1'b0;
        bus.req_cond     = '0;
        bus.req_imm      = 1'b0;
        bus.req_rn       = '0;
        bus.req_rd       = '0;
        bus.req_operand  = '0;
        bus.req_last     = 1'b0;
        bus.mem_wr_ready = 1'b1;

        // Pin the reference encoder against hand-computed words.
        check("pin_add", ref_encode(2'b00, 4'b0100, 1'b0, 4'hE, 1'b1, 4'd2, 4'd1, 24'h5), 32'hE282_1005);
        check("pin_ldr", ref_encode(2'b01, 4'h0, 1'b1, 4'hE, 1'b0, 4'd1, 4'd0, 24'h8), 32'hE491_0008);
        check("pin_b",   ref_encode(2'b10, 4'h0, 1'b0, 4'hE, 1'b0, 4'd0, 4'd0, 24'hFFFFFE), 32'hEAFF_FFFE);
        check("pin_cmp", ref_encode(2'b00, 4'b1010, 1'b0, 4'hE, 1'b0, 4'd3, 4'd7, 24'h4), 32'hE153_0004);
        check("pin_mov", ref_encode(2'b00, 4'b1101, 1'b0, 4'hE, 1'b1, 4'd9, 4'd2, 24'hFF), 32'hE3A0_20FF);

        // Reset state.
        cycles(3);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_mem_wr_valid", bus.mem_wr_valid, 0);
        check("rst_mem_wr_addr", bus.mem_wr_addr, 0);
        check("rst_mem_wr_data", bus.mem_wr_data, 0);
        check("rst_done", done, 0);
        check("rst_word_count", word_count, 0);
        rst = 1'b1;
        cycles(2);

        // ADD R1,R2,#5 as a one-word program at 0x100.
        clear_log();
        do_start(32'h100);
        send(2'b00, 4'b0100, 1'b0, 4'hE, 1'b1, 4'd2, 4'd1, 24'h5, 1'b1);
        wait_done(1, "add");
        check("add_nwrites", log_addr.size(), 1);
        if (log_addr.size() >= 1) begin
            check("add_addr", log_addr[0], 32'h100);
            check("add_data", log_data[0], 32'hE282_1005);
        end

        // LDR then branch, back to back.
        clear_log();
        do_start(32'h2000);
        send(2'b01, 4'h0, 1'b1, 4'hE, 1'b0, 4'd1, 4'd0, 24'h8, 1'b0);
        send(2'b10, 4'h0, 1'b0, 4'hE, 1'b0, 4'd0, 4'd0, 24'hFFFFFE, 1'b1);
        wait_done(2, "ldr_b");
        check("ldr_b_nwrites", log_addr.size(), 2);
        if (log_addr.size() >= 2) begin
            check("ldr_addr", log_addr[0], 32'h2000);
            check("ldr_data", log_data[0], 32'hE491_0008);
            check("b_addr", log_addr[1], 32'h2004);
            check("b_data", log_data[1], 32'hEAFF_FFFE);
        end

        // CMP with forced fields; then a start held during DONE is ignored.
        clear_log();
        do_start(32'h3000);
        send(2'b00, 4'b1010, 1'b0, 4'hE, 1'b0, 4'd3, 4'd7, 24'h4, 1'b1);
        begin
            int b = 0;
            while (!done && b < 100) begin
                @(posedge clk);
                #1;
                b++;
            end
            check("cmp_done_seen", done, 1);
            start = 1'b1;
            base_addr = 32'h5000;
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles(2);
            check("start_in_done_ignored", bus.req_ready, 0);
        end
        check("cmp_nwrites", log_addr.size(), 1);
        if (log_data.size() >= 1) check("cmp_data", log_data[0], 32'hE153_0004);

        // Back-pressure: six requests with the write port stalled.
        clear_log();
        bus.mem_wr_ready = 1'b0;
        do_start(32'h400);
        begin
            int acc0;
            acc0 = acc_count;
            for (int i = 0; i < 4; i++)
                send(2'b00, 4'b0100, 1'b0, 4'hE, 1'b1, 4'd2, 4'd1, 24'(i), 1'b0);
            present(2'b00, 4'b0100, 1'b0, 4'hE, 1'b1, 4'd2, 4'd1, 24'd4, 1'b0);
            cycles(6);
            check("stall_accepted", acc_count - acc0, 4);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_head_data", bus.mem_wr_data, 32'hE282_1000);
            check("stall_head_addr", bus.mem_wr_addr, 32'h400);
        end
        bus.mem_wr_ready = 1'b1;
        send(2'b00, 4'b0100, 1'b0, 4'hE, 1'b1, 4'd2, 4'd1, 24'd4, 1'b0);
        send(2'b00, 4'b0100, 1'b0, 4'hE, 1'b1, 4'd2, 4'd1, 24'd5, 1'b1);
        wait_done(6, "stall");
        check("stall_nwrites", log_addr.size(), 6);
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            check($sformatf("stall_addr%0d", i), log_addr[i], 32'h400 + 32'(4 * i));
            check($sformatf("stall_data%0d", i), log_data[i], 32'hE282_1000 + 32'(i));
        end

        // Address wrap at the top of the address space.
        clear_log();
        do_start(32'hFFFF_FFFC);
        send(2'b00, 4'b0100, 1'b0, 4'hE, 1'b1, 4'd2, 4'd1, 24'd0, 1'b0);
        send(2'b00, 4'b0100, 1'b0, 4'hE, 1'b1, 4'd2, 4'd1, 24'd1, 1'b1);
        wait_done(2, "wrap");
        check("wrap_nwrites", log_addr.size(), 2);
        if (log_addr.size() >= 2) begin
            check("wrap_addr0", log_addr[0], 32'hFFFF_FFFC);
            check("wrap_addr1", log_addr[1], 32'h0000_0000);
        end

        // Reset in the middle of a stalled load.
        bus.mem_wr_ready = 1'b0;
        do_start(32'h800);
        for (int i = 0; i < 3; i++)
            send(2'b00, 4'b0001, 1'b0, 4'h0, 1'b0, 4'd1, 4'd2, 24'(i), 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_valid", bus.mem_wr_valid, 0);
        check("midrst_addr", bus.mem_wr_addr, 0);
        check("midrst_data", bus.mem_wr_data, 0);
        check("midrst_word_count", word_count, 0);
        check("midrst_req_ready", bus.req_ready, 0);
        bus.mem_wr_ready = 1'b1;
        cycles(2);
        rst = 1'b1;
        clear_log();
        cycles(6);
        check("midrst_no_writes", log_addr.size(), 0);

`ifdef INSTR_ENCODER_CHECK_EN
        // Illegal mode-11 request followed by a legal last request.
        clear_log();
        do_start(32'h600);
        send(2'b11, 4'b0100, 1'b0, 4'hE, 1'b0, 4'd1, 4'd1, 24'h1, 1'b0);
        send(2'b00, 4'b0100, 1'b0, 4'hE, 1'b1, 4'd2, 4'd1, 24'h5, 1'b1);
        wait_done(1, "illegal");
        check("illegal_err", err, 1);
        check("illegal_nwrites", log_addr.size(), 1);
        // Illegal request carrying last: load ends with nothing written.
        clear_log();
        do_start(32'h700);
        check("err_cleared", err, 0);
        send(2'b00, 4'b0011, 1'b0, 4'hE, 1'b0, 4'd1, 4'd1, 24'h1, 1'b1);
        wait_done(0, "illegal_last");
        check("illegal_last_err", err, 1);
        check("illegal_last_nwrites", log_addr.size(), 0);
`endif

        // Randomized loads under random back-pressure.
        rand_ready = 1'b1;
        for (int l = 0; l < 12; l++) begin
            int n;
            int nlegal;
            n = $urandom_range(1, 8);
            nlegal = 0;
            clear_log();
            do_start($urandom & 32'hFFFF_FFFC);
            for (int i = 0; i < n; i++) begin
                logic [1:0]  mode;
                logic [3:0]  op;
                logic [23:0] operand;
                mode = 2'($urandom_range(0, 3));
                op   = 4'($urandom_range(0, 15));
                operand = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom & 32'hFFF);
                if (ref_legal(mode, op, operand)) nlegal++;
                if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
                send(mode, op, 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                     4'($urandom), operand, (i == n - 1));
            end
            wait_done(nlegal, "rand");
            check("rand_nwrites", log_addr.size(), 64'(nlegal));
        end
        rand_ready = 1'b0;
        bus.mem_wr_ready = 1'b1;
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
